// File: rtl/hyperbus_responder.sv
// ============================================================================
// Module   : hyperbus_responder
// Purpose  : HyperBus target emulating a small HyperRAM on a 16-bit memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hyperbus_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 6,
  parameter bit          FIXED_2X   = 1'b1,
  parameter logic [15:0] CFG0_RESET = 16'h8F1F
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       hb_rstn_i,
  input  logic       hb_csn_i,
  input  logic       hb_clk_i,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic [7:0] hb_dq_oen,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oen
);

  localparam int         c_lat_cyc = FIXED_2X ? 2 * LATENCY : LATENCY;
  localparam logic [7:0] c_first_r = 8'(3 + c_lat_cyc);
  localparam logic [7:0] c_oen_f   = 8'(2 + c_lat_cyc);
  localparam logic [7:0] c_ca_last = 8'd3;
  localparam logic [7:0] c_wreg_r  = 8'd4;
  localparam int         c_depth   = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_WDATA = 3'd3,
    S_RDATA = 3'd4,
    S_WREG  = 3'd5
  } state_t;

  // Input sampling stage
  logic       r_clk_s, r_clk_d, r_csn_s, r_csn_d, r_rstn_s, r_rwds_s;
  logic [7:0] r_dq_s;

  state_t                  r_state;
  logic [7:0]              r_rcnt;
  logic [39:0]             r_ca_hi;
  logic                    r_is_read, r_is_reg;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_wbuf_hi;
  logic                    r_wmask_hi;
  logic [15:0]             r_cfg;
  logic [7:0]              r_dq_o, r_dq_oen;
  logic                    r_rwds_o, r_rwds_oen;
  logic [15:0]             r_mem [0:c_depth-1];

  logic        w_rise, w_fall, w_csn_fall, w_abort;
  logic        w_data_rise, w_data_fall, w_mem_we;
  logic [7:0]  w_rcnt_nx;
  logic [47:0] w_ca;
  logic [31:0] w_ca_word;
  logic [15:0] w_rd_word;
  logic        w_unused_ca;

  assign w_rise     = r_clk_s & ~r_clk_d;
  assign w_fall     = ~r_clk_s & r_clk_d;
  assign w_csn_fall = r_csn_d & ~r_csn_s;
  assign w_abort    = r_csn_s | ~r_rstn_s;
  // Saturate so a long burst never aliases back onto a CA/WREG edge number
  assign w_rcnt_nx  = (r_rcnt == 8'hFF) ? r_rcnt : r_rcnt + 8'd1;

  assign w_ca        = {r_ca_hi, r_dq_s};
  assign w_ca_word   = {w_ca[44:16], w_ca[2:0]};
  assign w_unused_ca = ^{w_ca[45], w_ca[15:3], w_ca_word};

  assign w_data_rise = w_rise && ((r_state == S_LAT && w_rcnt_nx == c_first_r) ||
                                  r_state == S_WDATA || r_state == S_RDATA);
  assign w_data_fall = w_fall && (r_state == S_WDATA || r_state == S_RDATA);
  assign w_mem_we    = !w_abort && w_data_fall && (r_state == S_WDATA);
  assign w_rd_word   = r_is_reg ? r_cfg : r_mem[r_addr];

  assign hb_dq_o     = r_dq_o;
  assign hb_dq_oen   = r_dq_oen;
  assign hb_rwds_o   = r_rwds_o;
  assign hb_rwds_oen = r_rwds_oen;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_clk_s  <= 1'b0;
      r_clk_d  <= 1'b0;
      r_csn_s  <= 1'b1;
      r_csn_d  <= 1'b1;
      r_rstn_s <= 1'b1;
      r_dq_s   <= '0;
      r_rwds_s <= 1'b0;
    end else begin
      r_clk_s  <= hb_clk_i;
      r_clk_d  <= r_clk_s;
      r_csn_s  <= hb_csn_i;
      r_csn_d  <= r_csn_s;
      r_rstn_s <= hb_rstn_i;
      r_dq_s   <= hb_dq_i;
      r_rwds_s <= hb_rwds_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_rcnt     <= '0;
      r_ca_hi    <= '0;
      r_is_read  <= 1'b0;
      r_is_reg   <= 1'b0;
      r_addr     <= '0;
      r_wbuf_hi  <= '0;
      r_wmask_hi <= 1'b0;
      r_cfg      <= CFG0_RESET;
      r_dq_o     <= '0;
      r_dq_oen   <= 8'hFF;
      r_rwds_o   <= 1'b0;
      r_rwds_oen <= 1'b1;
    end else if (w_abort) begin
      // CSN high beats any coincident clock edge; partial words are dropped
      r_state    <= S_IDLE;
      r_dq_o     <= '0;
      r_dq_oen   <= 8'hFF;
      r_rwds_o   <= 1'b0;
      r_rwds_oen <= 1'b1;
      if (!r_rstn_s) r_cfg <= CFG0_RESET;
    end else begin
      if (w_rise) r_rcnt <= w_rcnt_nx;
      case (r_state)
        S_IDLE: begin
          if (w_csn_fall) begin
            r_state    <= S_CA;
            r_rcnt     <= '0;
            r_rwds_oen <= 1'b0;
            r_rwds_o   <= FIXED_2X;
          end
        end
        S_CA: begin
          if (w_fall && r_rcnt == c_ca_last) begin
            r_is_read <= w_ca[47];
            r_is_reg  <= w_ca[46];
            r_addr    <= w_ca_word[ADDR_WIDTH-1:0];
            if (!w_ca[47]) begin
              r_state    <= w_ca[46] ? S_WREG : S_LAT;
              r_rwds_oen <= 1'b1;
            end else begin
              r_state  <= S_LAT;
              r_rwds_o <= 1'b0;
            end
          end else if (w_rise || w_fall) begin
            r_ca_hi <= {r_ca_hi[31:0], r_dq_s};
          end
        end
        S_LAT: begin
          if (w_data_rise) r_state <= r_is_read ? S_RDATA : S_WDATA;
          if (w_fall && r_is_read && r_rcnt == c_oen_f) r_dq_oen <= '0;
        end
        S_WREG: begin
          if (w_rise && w_rcnt_nx == c_wreg_r) r_cfg[15:8] <= r_dq_s;
          if (w_fall && r_rcnt == c_wreg_r)    r_cfg[7:0]  <= r_dq_s;
        end
        default: ;
      endcase

      if (w_data_rise) begin
        if (r_is_read) begin
          r_dq_o   <= w_rd_word[15:8];
          r_rwds_o <= 1'b1;
        end else begin
          r_wbuf_hi  <= r_dq_s;
          r_wmask_hi <= r_rwds_s;
        end
      end
      if (w_data_fall) begin
        if (r_is_read) begin
          r_dq_o   <= w_rd_word[7:0];
          r_rwds_o <= 1'b0;
        end
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Memory contents survive reset; a high RWDS sample masks that byte
  always_ff @(posedge wb_clk_i) begin
    if (w_mem_we) begin
      if (!r_wmask_hi) r_mem[r_addr][15:8] <= r_wbuf_hi;
      if (!r_rwds_s)   r_mem[r_addr][7:0]  <= r_dq_s;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hyperbus_responder.sv
// ============================================================================
// Module   : tb_hyperbus_responder
// Purpose  : Directed scoreboard bench for hyperbus_responder (2x and 1x DUTs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hyperbus_responder;

  logic       wb_clk_i  = 1'b0;
  logic       wb_rst_i  = 1'b1;
  logic       hb_rstn_i = 1'b1;
  logic       hb_csn_i  = 1'b1;
  logic       hb_clk_i  = 1'b0;
  logic [7:0] hb_dq_i   = 8'h00;
  logic       hb_rwds_i = 1'b0;

  logic [7:0] dq_o_a, dq_oen_a, dq_o_b, dq_oen_b;
  logic       rwds_o_a, rwds_oen_a, rwds_o_b, rwds_oen_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  sb_q[$];
  logic [15:0] model[int];
  logic [15:0] model_cfg = 16'h8F1F;
  logic [15:0] tx_data[8];
  logic [1:0]  tx_mask[8];

  always #5 wb_clk_i = ~wb_clk_i;

  hyperbus_responder #(
    .ADDR_WIDTH(10), .LATENCY(6), .FIXED_2X(1'b1), .CFG0_RESET(16'h8F1F)
  ) u_dut2x (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .hb_rstn_i(hb_rstn_i),
    .hb_csn_i(hb_csn_i), .hb_clk_i(hb_clk_i), .hb_dq_i(hb_dq_i),
    .hb_dq_o(dq_o_a), .hb_dq_oen(dq_oen_a), .hb_rwds_i(hb_rwds_i),
    .hb_rwds_o(rwds_o_a), .hb_rwds_oen(rwds_oen_a)
  );

  hyperbus_responder #(
    .ADDR_WIDTH(10), .LATENCY(6), .FIXED_2X(1'b0), .CFG0_RESET(16'h8F1F)
  ) u_dut1x (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .hb_rstn_i(hb_rstn_i),
    .hb_csn_i(hb_csn_i), .hb_clk_i(hb_clk_i), .hb_dq_i(hb_dq_i),
    .hb_dq_o(dq_o_b), .hb_dq_oen(dq_oen_b), .hb_rwds_i(hb_rwds_i),
    .hb_rwds_o(rwds_o_b), .hb_rwds_oen(rwds_oen_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // One hb_clk half period: data set up 2 cycles before the edge, held 2 after
  task automatic half(input logic [7:0] d, input logic m);
    hb_dq_i   = d;
    hb_rwds_i = m;
    wait_neg(2);
    hb_clk_i = ~hb_clk_i;
    wait_neg(2);
  endtask

  function automatic logic [8:0] obs_byte(input bit sel1x);
    return sel1x ? {rwds_o_b, dq_o_b} : {rwds_o_a, dq_o_a};
  endfunction

  task automatic set_tx(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    tx_data[0] = d0; tx_data[1] = d1; tx_data[2] = d2;
    for (int i = 0; i < 8; i++) tx_mask[i] = 2'b00;
  endtask

  // abort_w: word index after whose R edge the burst is cut (-1 = none);
  // abort_rst selects a wb_rst_i pulse instead of CSN rising.
  task automatic xfer(input string tag, input bit rd, input bit rsp, input logic [31:0] addr,
                      input int nw, input bit sel1x, input int abort_w, input bit abort_rst);
    logic [47:0] ca;
    logic [15:0] d, exp, cur;
    logic [8:0]  e;
    int          first_r, key;
    ca = '0;
    ca[47] = rd;
    ca[46] = rsp;
    ca[44:16] = addr[31:3];
    ca[2:0] = addr[2:0];
    first_r = (rsp && !rd) ? 4 : (sel1x ? 9 : 15);

    hb_clk_i = 1'b0;
    hb_csn_i = 1'b0;
    wait_neg(2);
    for (int i = 0; i < 6; i++) begin
      half(ca[47-8*i -: 8], 1'b0);
      if (i == 1) begin
        check({tag, ".ca_rwds_oen"}, {15'd0, sel1x ? rwds_oen_b : rwds_oen_a}, 16'd0);
        check({tag, ".ca_rwds"}, {15'd0, sel1x ? rwds_o_b : rwds_o_a}, {15'd0, !sel1x});
      end
    end
    if (!rd) check({tag, ".wr_rwds_rel"}, {15'd0, sel1x ? rwds_oen_b : rwds_oen_a}, 16'd1);
    for (int k = 4; k < first_r; k++) begin
      half(8'h00, 1'b0);
      half(8'h00, 1'b0);
    end

    for (int w = 0; w < nw; w++) begin
      key = ((int'(addr) + w) % 1024) + (sel1x ? 1024 : 0);
      d = tx_data[w];
      if (rd) begin
        exp = rsp ? model_cfg : (model.exists(key) ? model[key] : 16'hxxxx);
        sb_q.push_back({1'b1, exp[15:8]});
        sb_q.push_back({1'b0, exp[7:0]});
      end
      half(rd ? 8'h00 : d[15:8], rd ? 1'b0 : tx_mask[w][1]);
      if (rd) begin
        e = sb_q.pop_front();
        check($sformatf("%s.w%0d.hi", tag, w), {7'd0, obs_byte(sel1x)}, {7'd0, e});
        check($sformatf("%s.w%0d.oen", tag, w), {8'd0, sel1x ? dq_oen_b : dq_oen_a}, 16'd0);
      end
      if (w == abort_w) begin
        if (abort_rst) begin
          #2 wb_rst_i = 1'b1;
          #1;
          check({tag, ".rst_dq_oen"}, {8'd0, dq_oen_a}, 16'h00FF);
          check({tag, ".rst_rwds_oen"}, {15'd0, rwds_oen_a}, 16'd1);
          hb_csn_i = 1'b1;
          hb_clk_i = 1'b0;
          wait_neg(2);
          wb_rst_i = 1'b0;
          model_cfg = 16'h8F1F;
        end else begin
          hb_csn_i = 1'b1;
          wait_neg(2);
          check({tag, ".abort_dq_oen"}, {8'd0, sel1x ? dq_oen_b : dq_oen_a}, 16'h00FF);
          check({tag, ".abort_rwds_oen"}, {15'd0, sel1x ? rwds_oen_b : rwds_oen_a}, 16'd1);
          hb_clk_i = 1'b0;
        end
        sb_q.delete();
        wait_neg(4);
        return;
      end
      half(rd ? 8'h00 : d[7:0], rd ? 1'b0 : tx_mask[w][0]);
      if (rd) begin
        e = sb_q.pop_front();
        check($sformatf("%s.w%0d.lo", tag, w), {7'd0, obs_byte(sel1x)}, {7'd0, e});
      end else if (rsp) begin
        model_cfg = d;
      end else begin
        cur = model.exists(key) ? model[key] : 16'hxxxx;
        if (!tx_mask[w][1]) cur[15:8] = d[15:8];
        if (!tx_mask[w][0]) cur[7:0]  = d[7:0];
        model[key] = cur;
      end
    end
    wait_neg(2);
    hb_csn_i = 1'b1;
    wait_neg(4);
    check({tag, ".end_dq_oen"}, {8'd0, sel1x ? dq_oen_b : dq_oen_a}, 16'h00FF);
    check({tag, ".end_rwds_oen"}, {15'd0, sel1x ? rwds_oen_b : rwds_oen_a}, 16'd1);
  endtask

  initial begin
    wait_neg(3);
    wb_rst_i = 1'b0;
    wait_neg(2);
    check("reset.dq_oen", {8'd0, dq_oen_a}, 16'h00FF);
    check("reset.rwds_oen", {15'd0, rwds_oen_a}, 16'd1);
    check("reset.dq_o", {8'd0, dq_o_a}, 16'd0);
    check("reset.rwds_o", {15'd0, rwds_o_a}, 16'd0);

    // Write then read, first byte after R15
    set_tx(16'h1234, 16'hABCD, 16'h0000);
    xfer("wr010", 1'b0, 1'b0, 32'h010, 2, 1'b0, -1, 1'b0);
    check("model010", model[16'h010], 16'h1234);
    xfer("rd010", 1'b1, 1'b0, 32'h010, 2, 1'b0, -1, 1'b0);

    // Byte mask on the high byte
    set_tx(16'hFFFF, 16'h0000, 16'h0000);
    xfer("wr020a", 1'b0, 1'b0, 32'h020, 1, 1'b0, -1, 1'b0);
    set_tx(16'h0000, 16'h0000, 16'h0000);
    tx_mask[0] = 2'b10;
    xfer("wr020b", 1'b0, 1'b0, 32'h020, 1, 1'b0, -1, 1'b0);
    check("model020", model[16'h020], 16'hFF00);
    xfer("rd020", 1'b1, 1'b0, 32'h020, 1, 1'b0, -1, 1'b0);

    // Address wrap 0x3FF -> 0x000 -> 0x001
    set_tx(16'hA001, 16'hA002, 16'hA003);
    xfer("wrwrap", 1'b0, 1'b0, 32'h3FF, 3, 1'b0, -1, 1'b0);
    xfer("rdwrap", 1'b1, 1'b0, 32'h3FF, 3, 1'b0, -1, 1'b0);

    // Abort after the R edge of word 2 discards that partial word
    set_tx(16'h5555, 16'h6666, 16'h0000);
    xfer("wr030a", 1'b0, 1'b0, 32'h030, 2, 1'b0, -1, 1'b0);
    set_tx(16'h1111, 16'h2222, 16'h0000);
    xfer("wr030b", 1'b0, 1'b0, 32'h030, 2, 1'b0, 1, 1'b0);
    check("model031", model[16'h031], 16'h6666);
    xfer("rd030", 1'b1, 1'b0, 32'h030, 2, 1'b0, -1, 1'b0);

    // Read aborted by CSN while DQ is driven
    xfer("rdabort", 1'b1, 1'b0, 32'h010, 2, 1'b0, 0, 1'b0);

    // Register space write/read, then system reset mid-burst
    set_tx(16'h8E17, 16'h0000, 16'h0000);
    xfer("wrcfg", 1'b0, 1'b1, 32'h0, 1, 1'b0, -1, 1'b0);
    xfer("rdcfg", 1'b1, 1'b1, 32'h0, 2, 1'b0, -1, 1'b0);
    xfer("rdrst", 1'b1, 1'b0, 32'h010, 2, 1'b0, 0, 1'b1);
    xfer("rdcfg_rst", 1'b1, 1'b1, 32'h0, 1, 1'b0, -1, 1'b0);

    // HyperBus reset restores the configuration register
    set_tx(16'h1234, 16'h0000, 16'h0000);
    xfer("wrcfg2", 1'b0, 1'b1, 32'h0, 1, 1'b0, -1, 1'b0);
    hb_rstn_i = 1'b0;
    wait_neg(4);
    hb_rstn_i = 1'b1;
    model_cfg = 16'h8F1F;
    wait_neg(4);
    xfer("rdcfg_hbrst", 1'b1, 1'b1, 32'h0, 1, 1'b0, -1, 1'b0);

    // Single-latency instance: RWDS low in CA, data from R9
    set_tx(16'hC0DE, 16'hBEEF, 16'h0000);
    xfer("wr1x", 1'b0, 1'b0, 32'h040, 2, 1'b1, -1, 1'b0);
    xfer("rd1x", 1'b1, 1'b0, 32'h040, 2, 1'b1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyperbus_responder.md
Name: hyperbus_responder

Overview:
- Synthesizable HyperBus target (device side) that emulates a small HyperRAM, backed by an internal 16-bit-wide memory array.
- Connects pin-for-pin to the controller's HyperBus signals in loopback benches and FPGA builds, replacing the behavioural memory model.
- Samples the HyperBus clock as data in the system clock domain. Both hb_clk_i edges are detected synchronously.

Parameters:
- ADDR_WIDTH, 10, word-address width; memory depth is 2^ADDR_WIDTH x 16 bits.
- LATENCY, 6, initial latency in hb_clk cycles.
- FIXED_2X, 1, 1 = always use double latency and drive RWDS high during CA; 0 = single latency, RWDS low.
- CFG0_RESET, 16'h8F1F, reset value of the configuration register.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- hb_rstn_i  in  1  HyperBus reset, active-low
- hb_csn_i  in  1  chip select, active-low
- hb_clk_i  in  1  HyperBus clock
- hb_dq_i  in  8  DQ input
- hb_dq_o  out  8  DQ output
- hb_dq_oen  out  8  DQ output disable; 1 = Z
- hb_rwds_i  in  1  RWDS input (write mask)
- hb_rwds_o  out  1  RWDS output
- hb_rwds_oen  out  1  RWDS output disable; 1 = Z

Behaviour:
- **Reset.** hb_dq_o=0, hb_dq_oen=8'hFF, hb_rwds_o=0, hb_rwds_oen=1, state IDLE, cfg_reg=CFG0_RESET. Memory contents are not reset.
- **Edge detection.** hb_clk_i, hb_csn_i and hb_dq_i/hb_rwds_i are registered once. An edge is detected when the registered clock differs from its previous value.
  - Each hb_clk half-period must be at least 2 wb_clk_i cycles.
  - Rising edges after CSN falls are numbered R1, R2, ...; falling edges F1, F2, ...
- **States:** IDLE, CA, LAT, WDATA, RDATA, WREG.
- **IDLE -> CA** on registered hb_csn_i falling. In the next cycle, hb_rwds_oen=0 and hb_rwds_o=FIXED_2X.
- **CA.** Capture CA[47:40]..CA[7:0] at R1, F1, R2, F2, R3, F3 (MSB byte first).
  - CA[47] = read; CA[46] = register space.
  - Word address = {CA[44:16], CA[2:0]}, truncated to ADDR_WIDTH bits.
  - After F3:
    - register write -> WREG; RWDS released.
    - memory write -> LAT; RWDS released.
    - any read -> LAT; hb_rwds_o=0, RWDS still driven.
- **Latency.** LAT_CYC = FIXED_2X ? 2*LATENCY : LATENCY. The first data edge is R(3+LAT_CYC); with the defaults this is R15.
- **WDATA.**
  - Sample the high byte at each R and the low byte at the following F.
  - hb_rwds_i=1 at a sample masks that byte (not written).
  - Commit the word at F, then increment the address.
- **RDATA.**
  - hb_dq_oen=00 from the cycle after F(2+LAT_CYC).
  - In the cycle after each Rk: hb_dq_o = mem[addr][15:8], hb_rwds_o=1.
  - In the cycle after each Fk: hb_dq_o = mem[addr][7:0], hb_rwds_o=0; address increments.
  - Register-space reads return cfg_reg for every word.
- **WREG.** Zero latency: cfg_reg[15:8] at R4, cfg_reg[7:0] at F4. RWDS mask is ignored. Further edges are ignored.
- **Burst.** Linear, unbounded length. The address wraps from 2^ADDR_WIDTH-1 to 0.
- **Termination.** Registered hb_csn_i high in any state:
  - -> IDLE.
  - In the next cycle, hb_dq_oen=FF and hb_rwds_oen=1.
  - A partial word (R seen, F not seen) is discarded.
- **HyperBus reset.** hb_rstn_i low -> IDLE and outputs released, as for CSN high; cfg_reg is reset to CFG0_RESET.
- **System reset.** wb_rst_i mid-burst releases all drivers asynchronously.
- **Priority.** When CSN rises in the same cycle as a clock edge, CSN wins and no data is committed.

Test Plan:
- **Write then read.** Write burst to word 0x010: 0x1234, 0xABCD (RWDS low). Read burst of 2 from 0x010 -> DQ bytes 12,34,AB,CD with RWDS 1,0,1,0, first byte following R15.
- **Byte mask.** Write 0xFFFF to 0x020, then write 0x0000 with RWDS high at the R byte. Read -> 0xFF00.
- **Address wrap.** Write 3 words starting at 0x3FF (ADDR_WIDTH=10) -> reads of 0x3FF, 0x000, 0x001 return those 3 words in order.
- **Abort.** Write burst 0x1111, 0x2222; raise CSN after the R edge of word 2. Read 2 words -> word 1 = 0x1111, word 2 unchanged. Drivers are Z one cycle after CSN rises.
- **Register access.** Register write CA[46]=1 with value 0x8E17 -> subsequent register read returns 0x8E17. After a wb_rst_i pulse, the register read returns 0x8F1F.
- **Latency indication.** With FIXED_2X=1, hb_rwds_o=1 and hb_rwds_oen=0 throughout CA. With FIXED_2X=0, RWDS reads low during CA and data starts at R9.
